// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel arbitration stage.
package dma_pkg;

  localparam int NUM_CH = 4;

  // Fixed order: channel 0 highest ([1:0]) down to channel 3 lowest ([7:6]).
  localparam logic [7:0] DEFAULT_PRIORITY = 8'b11_10_01_00;

  // Command register bit positions feeding this stage.
  localparam int ROT_PRI  = 4;
  localparam int CTRL_DIS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_GRANT = 2'd2
  } arb_state_e;

  // After serving channel g, g drops to lowest and g+1 becomes highest.
  // Each element is self-determined 2-bit, so the sums wrap modulo 4.
  function automatic logic [7:0] rotate_after(input logic [1:0] g);
    rotate_after = {g, g + 2'd3, g + 2'd2, g + 2'd1};
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Picks the first requesting channel when scanning priorityOrder from
// the highest slot ([1:0]) to the lowest ([7:6]). Purely combinational.
module dma_priority_encoder (
  input  logic [3:0] effReq,
  input  logic [7:0] priorityOrder,
  output logic [1:0] winner,
  output logic       any
);

  // Scan lowest slot first so the highest-priority hit is written last.
  always_comb begin
    winner = 2'd0;
    any    = |effReq;
    for (int i = 3; i >= 0; i--) begin
      if (effReq[priorityOrder[2*i +: 2]]) begin
        winner = priorityOrder[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Request arbitration for the 4-channel DMA controller: raises HRQ,
// grants one channel on HLDA and maintains the fixed/rotating order.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no request outstanding, bus not held
// ARB_REQ   | HRQ raised, waiting for HLDA
// ARB_GRANT | winner latched, DACK driven until serviceDone or HLDA loss
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic              rotatingPriority,
  input  logic              controllerDisable,
  input  logic              serviceDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [1:0]        grantChannel,
  output logic [7:0]        priorityOrder
);

  import dma_pkg::*;

  arb_state_e        state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic              grant_valid_q, grant_valid_d;
  logic [1:0]        grant_channel_q, grant_channel_d;
  logic [7:0]        priority_order_q, priority_order_d;

  logic [NUM_CH-1:0] eff_req;
  logic [1:0]        enc_winner;
  logic              enc_any;

  // Software requests bypass the mask; disable blocks everything.
  assign eff_req = ((DREQ & ~maskReg) | requestReg) & {NUM_CH{~controllerDisable}};

  dma_priority_encoder u_enc (
    .effReq        (eff_req),
    .priorityOrder (priority_order_q),
    .winner        (enc_winner),
    .any           (enc_any)
  );

  // Next-state and next-output logic; outputs are computed here so they
  // land in flops together with the state.
  always_comb begin
    state_d          = state_q;
    hrq_d            = hrq_q;
    dack_d           = dack_q;
    grant_valid_d    = grant_valid_q;
    grant_channel_d  = grant_channel_q;
    priority_order_d = priority_order_q;

    case (state_q)
      ARB_IDLE: begin
        if (enc_any) begin
          state_d = ARB_REQ;
          hrq_d   = 1'b1;
        end
      end

      ARB_REQ: begin
        if (!enc_any) begin
          state_d = ARB_IDLE;
          hrq_d   = 1'b0;
        end else if (HLDA) begin
          state_d             = ARB_GRANT;
          grant_valid_d       = 1'b1;
          grant_channel_d     = enc_winner;
          dack_d              = '0;
          dack_d[enc_winner]  = 1'b1;
        end
      end

      ARB_GRANT: begin
        // The winner is frozen here; requests and masks are not looked at.
        if (serviceDone) begin
          state_d       = ARB_IDLE;
          hrq_d         = 1'b0;
          dack_d        = '0;
          grant_valid_d = 1'b0;
          if (rotatingPriority) begin
            priority_order_d = rotate_after(grant_channel_q);
          end
        end else if (!HLDA) begin
          state_d       = ARB_IDLE;
          hrq_d         = 1'b0;
          dack_d        = '0;
          grant_valid_d = 1'b0;
        end
      end

      default: begin
        state_d       = ARB_IDLE;
        hrq_d         = 1'b0;
        dack_d        = '0;
        grant_valid_d = 1'b0;
      end
    endcase

    // Fixed mode continuously reloads the default order.
    if (!rotatingPriority) begin
      priority_order_d = DEFAULT_PRIORITY;
    end
  end

  // State and registered outputs, cleared immediately on reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= ARB_IDLE;
      hrq_q            <= 1'b0;
      dack_q           <= '0;
      grant_valid_q    <= 1'b0;
      grant_channel_q  <= 2'd0;
      priority_order_q <= DEFAULT_PRIORITY;
    end else begin
      state_q          <= state_d;
      hrq_q            <= hrq_d;
      dack_q           <= dack_d;
      grant_valid_q    <= grant_valid_d;
      grant_channel_q  <= grant_channel_d;
      priority_order_q <= priority_order_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantValid    = grant_valid_q;
  assign grantChannel  = grant_channel_q;
  assign priorityOrder = priority_order_q;

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel priority and request arbitration stage of the 4-channel DMA controller. Combines external DREQ, software requests and mask bits into effective requests and raises HRQ to the CPU. On HLDA it selects one channel under fixed or rotating priority and drives DACK, then hands the granted channel to the timing-control state machine downstream. It owns the `priorityOrder` and `DACK` state that the reset checker inspects.

## Interface
- Parameters: `NUM_CH`, default 4, number of channels; only 4 is supported.
- `CLK`  in  1  system clock; all state updates on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `DREQ`  in  4  external DMA requests, active-high, level-sensitive.
- `HLDA`  in  1  CPU hold acknowledge.
- `maskReg`  in  4  per-channel mask; 1 blocks DREQ for that channel.
- `requestReg`  in  4  software requests, unmasked, OR'd with DREQ.
- `rotatingPriority`  in  1  command register bit 4; 1 selects rotating, 0 selects fixed.
- `controllerDisable`  in  1  command register bit 2; 1 blocks new arbitration.
- `serviceDone`  in  1  one-cycle pulse from timing control at end of service (TC/EOP or single-transfer end).
- `HRQ`  out  1  hold request to CPU.
- `DACK`  out  4  one-hot acknowledge, active-high.
- `grantValid`  out  1  a channel is granted.
- `grantChannel`  out  2  granted channel index; valid while `grantValid`.
- `priorityOrder`  out  8  four 2-bit channel IDs; [1:0] is highest priority, [7:6] is lowest.

## Operation
- Effective request: `effReq = ((DREQ & ~maskReg) | requestReg) & {4{~controllerDisable}}`.
- FSM states:
  - IDLE: HRQ=0, DACK=0, grantValid=0. Goes to REQ when `effReq != 0`.
  - REQ: HRQ=1.
    - If `effReq == 0` and HLDA=0, return to IDLE; the request is withdrawn.
    - If HLDA=1 and `effReq != 0`, go to GRANT. Latch the winner: the first channel in `priorityOrder`, scanning [1:0] up to [7:6], whose `effReq` bit is set.
    - If HLDA=1 and `effReq == 0`, return to IDLE.
  - GRANT: HRQ=1, grantValid=1, `DACK[grantChannel]`=1.
    - The winner is frozen for the whole service. Higher-priority requests, mask changes and `controllerDisable` do not pre-empt it.
    - On `serviceDone`, go to IDLE.
    - If HLDA falls without `serviceDone`, go to IDLE (CPU reclaimed the bus) and leave `priorityOrder` unchanged.
- Priority update, applied only on `serviceDone` in GRANT with `rotatingPriority`=1, for granted channel g:
  - New order, highest to lowest: (g+1)%4, (g+2)%4, (g+3)%4, g.
  - Example: g=1 gives 8'b01_00_11_10.
- While `rotatingPriority`=0, `priorityOrder` is loaded with 8'b11_10_01_00 on every clock.
- Index arithmetic is 2-bit and wraps modulo 4.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE.
  - HRQ=0, DACK=4'b0000, grantValid=0, grantChannel=2'b00.
  - priorityOrder=8'b11_10_01_00.
- Reset asserted mid-GRANT: all outputs take reset values at once, with no `serviceDone` handshake. After deassertion the first arbitration is fixed-order.
- All outputs are registered. Each FSM transition is visible one cycle after the sampled condition.
- Request to HRQ latency: 1 cycle (`effReq` sampled at edge N, HRQ high after edge N).
- HLDA to DACK/grantValid latency: 1 cycle.
- `serviceDone` at edge N:
  - HRQ, DACK and grantValid are low after edge N.
  - The rotated `priorityOrder` is visible after edge N.
  - IDLE lasts at least 1 cycle before the next REQ, so HRQ has a minimum low time of 1 cycle between services.
- `serviceDone` outside GRANT is ignored.
- All four channels requesting simultaneously resolve to the channel in `priorityOrder[1:0]`.

## Structure
- Shared package `dma_pkg` holds:
  - Arbiter state enum (IDLE, REQ, GRANT).
  - `DEFAULT_PRIORITY` = 8'b11_10_01_00.
  - `NUM_CH` = 4.
  - Command-register bit-position constants (ROT_PRI=4, CTRL_DIS=2).
- Sub-module `dma_priority_encoder` is purely combinational: inputs `effReq[3:0]` and `priorityOrder[7:0]`; outputs `winner[1:0]` and `any`.
- The top level holds the FSM, the winner latch, the `priorityOrder` register and the DACK decode.

## Test plan
- Reset mid-GRANT on channel 2: assert RESET asynchronously → DACK=0000, HRQ=0 and priorityOrder=8'b11_10_01_00 without waiting for a clock edge.
- Fixed priority: DREQ=4'b1010, HLDA raised 2 cycles after HRQ → grantChannel=1, DACK=0010; after `serviceDone`, priorityOrder stays 8'b11_10_01_00.
- Rotating priority: rotatingPriority=1, DREQ=4'b1111, serve three times back to back → grants 0, 1, 2 in order; priorityOrder after the third service = 8'b10_01_00_11.
- Mask and software request: maskReg=4'b0001, DREQ=4'b0001, requestReg=0 → HRQ stays 0; then requestReg=4'b0001 → HRQ=1 next cycle.
- Request withdrawal: DREQ[3] pulsed for 1 cycle with HLDA held 0 → HRQ is high for exactly 1 cycle, then IDLE, DACK never asserted.
- Pre-emption and HLDA loss: grant channel 3 (rotating), raise DREQ[0] mid-GRANT → DACK stays 1000; then drop HLDA → IDLE and priorityOrder unchanged.
